// File: rtl/brg_slave_xcel_dispatcher_if.sv
// Bus bundle between the manycore endpoint, the dispatcher and the accelerator array.
// The slave modport is the dispatcher's view; master is the endpoint/xcel side.
interface brg_slave_xcel_dispatcher_if #(
  parameter int unsigned num_xcel_p   = 4,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32
);
  logic                               in_v_i;
  logic [addr_width_p-1:0]            in_addr_i;
  logic [data_width_p-1:0]            in_data_i;
  logic [data_width_p/8-1:0]          in_mask_i;
  logic                               in_we_i;
  logic                               in_yumi_o;
  logic                               returning_v_o;
  logic [data_width_p-1:0]            returning_data_o;
  logic [num_xcel_p-1:0]              xcel_v_o;
  logic [addr_width_p-1:0]            xcel_addr_o;
  logic [data_width_p-1:0]            xcel_data_o;
  logic [data_width_p/8-1:0]          xcel_mask_o;
  logic                               xcel_we_o;
  logic [num_xcel_p-1:0]              xcel_yumi_i;
  logic [num_xcel_p-1:0]              xcel_ret_v_i;
  logic [num_xcel_p*data_width_p-1:0] xcel_ret_data_i;

  modport slave (
    input  in_v_i, in_addr_i, in_data_i, in_mask_i, in_we_i,
           xcel_yumi_i, xcel_ret_v_i, xcel_ret_data_i,
    output in_yumi_o, returning_v_o, returning_data_o,
           xcel_v_o, xcel_addr_o, xcel_data_o, xcel_mask_o, xcel_we_o
  );

  modport master (
    output in_v_i, in_addr_i, in_data_i, in_mask_i, in_we_i,
           xcel_yumi_i, xcel_ret_v_i, xcel_ret_data_i,
    input  in_yumi_o, returning_v_o, returning_data_o,
           xcel_v_o, xcel_addr_o, xcel_data_o, xcel_mask_o, xcel_we_o
  );
endinterface

// File: rtl/brg_slave_xcel_dispatcher.sv
// Shares one endpoint slave port among num_xcel_p accelerators: one request in flight,
// address-field select, per-request timeout, error response for unmapped/timed-out requests.
module brg_slave_xcel_dispatcher #(
  parameter int unsigned num_xcel_p   = 4,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned sel_lsb_p    = 10,
  parameter int unsigned sel_width_p  = 2,
  parameter int unsigned timeout_p    = 1024,
  parameter logic [data_width_p-1:0] err_data_p = 32'hDEADBEEF
) (
  input  logic clk_i,
  input  logic reset_n_i,
  brg_slave_xcel_dispatcher_if.slave bus,
  output logic busy_o,
  output logic err_o
);

  localparam int unsigned mask_width_lp = data_width_p / 8;
  localparam int unsigned ctr_width_lp  = $clog2(timeout_p + 1);
  localparam logic [ctr_width_lp-1:0] ctr_last_lp = ctr_width_lp'(timeout_p - 1);
  localparam logic [sel_width_p:0]    sel_lim_lp  = (sel_width_p + 1)'(num_xcel_p);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_RET
  } state_e;

  state_e                      r_state;
  logic [sel_width_p-1:0]      r_sel;
  logic [ctr_width_lp-1:0]     r_ctr;
  logic [data_width_p-1:0]     r_resp;
  logic [num_xcel_p-1:0]       r_xcel_v;
  logic [addr_width_p-1:0]     r_addr;
  logic [data_width_p-1:0]     r_data;
  logic [mask_width_lp-1:0]    r_mask;
  logic                        r_we;
  logic                        r_yumi;
  logic                        r_ret_v;
  logic                        r_busy;
  logic                        r_err;

  logic [sel_width_p-1:0]      w_in_sel;
  logic                        w_in_mapped;
  logic [num_xcel_p-1:0]       w_in_onehot;
  logic                        w_sel_yumi;
  logic                        w_sel_ret;
  logic [data_width_p-1:0]     w_sel_data;
  logic                        w_done;
  logic                        w_expire;

  assign w_in_sel    = bus.in_addr_i[sel_lsb_p +: sel_width_p];
  assign w_in_mapped = ({1'b0, w_in_sel} < sel_lim_lp);

  // Only the latched target's handshake is observed; every other xcel is ignored.
  always_comb begin
    w_in_onehot = '0;
    w_sel_yumi  = 1'b0;
    w_sel_ret   = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < num_xcel_p; i++) begin
      if (i == 32'(w_in_sel)) w_in_onehot[i] = 1'b1;
      if (i == 32'(r_sel)) begin
        w_sel_yumi = bus.xcel_yumi_i[i];
        w_sel_ret  = bus.xcel_ret_v_i[i];
        w_sel_data = bus.xcel_ret_data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  assign w_done   = ((r_state == S_ISSUE) && w_sel_yumi && w_sel_ret) ||
                    ((r_state == S_WAIT) && w_sel_ret);
  assign w_expire = (r_ctr == ctr_last_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_ctr    <= '0;
      r_resp   <= '0;
      r_xcel_v <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_mask   <= '0;
      r_we     <= 1'b0;
      r_yumi   <= 1'b0;
      r_ret_v  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_yumi  <= 1'b0;
      r_ret_v <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_v_i) begin
            r_addr <= bus.in_addr_i;
            r_data <= bus.in_data_i;
            r_mask <= bus.in_mask_i;
            r_we   <= bus.in_we_i;
            r_sel  <= w_in_sel;
            r_busy <= 1'b1;
            if (w_in_mapped) begin
              r_state  <= S_ISSUE;
              r_ctr    <= '0;
              r_xcel_v <= w_in_onehot;
            end else begin
              r_state <= S_ACK;
              r_resp  <= err_data_p;
              r_err   <= 1'b1;
              r_yumi  <= 1'b1;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          // Completion wins over expiry when both land on the final counted cycle.
          r_ctr <= r_ctr + 1'b1;
          if (w_done) begin
            r_state  <= S_ACK;
            r_resp   <= w_sel_data;
            r_yumi   <= 1'b1;
            r_xcel_v <= '0;
          end else if (w_expire) begin
            r_state  <= S_ACK;
            r_resp   <= err_data_p;
            r_err    <= 1'b1;
            r_yumi   <= 1'b1;
            r_xcel_v <= '0;
          end else if ((r_state == S_ISSUE) && w_sel_yumi) begin
            r_state  <= S_WAIT;
            r_xcel_v <= '0;
          end
        end
        S_ACK: begin
          r_state <= S_RET;
          r_ret_v <= 1'b1;
        end
        S_RET: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_xcel_v <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_yumi_o        = r_yumi;
  assign bus.returning_v_o    = r_ret_v;
  assign bus.returning_data_o = r_resp;
  assign bus.xcel_v_o         = r_xcel_v;
  assign bus.xcel_addr_o      = r_addr;
  assign bus.xcel_data_o      = r_data;
  assign bus.xcel_mask_o      = r_mask;
  assign bus.xcel_we_o        = r_we;
  assign busy_o               = r_busy;
  assign err_o                = r_err;

endmodule

// File: tb/tb_brg_slave_xcel_dispatcher.sv
// Scoreboard bench for brg_slave_xcel_dispatcher: three xcels, short timeout, so the
// select field value 3 is unmapped and timeouts are cheap to reach.
module tb_brg_slave_xcel_dispatcher;
  localparam int NX = 3;
  localparam int TO = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset_n_i;
  logic busy_o, err_o;
  always #5 clk = ~clk;

  brg_slave_xcel_dispatcher_if #(.num_xcel_p(NX), .addr_width_p(32), .data_width_p(32)) bus ();

  brg_slave_xcel_dispatcher #(.num_xcel_p(NX), .timeout_p(TO)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .bus(bus), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] data;
    int          ycyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   model_err = 1'b0;
  bit   prev_yumi = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Monitor: yumi must arrive on the predicted cycle; returning follows yumi by one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n_i) prev_yumi = 1'b0;
    else begin
      if (bus.returning_v_o) begin
        chk("ret_after_yumi", 64'(prev_yumi), 64'd1);
        if (sb.size() == 0) fail_evt("returning_v_unexpected");
        else begin
          e = sb.pop_front();
          chk("returning_data", 64'(bus.returning_data_o), 64'(e.data));
        end
      end
      if (bus.in_yumi_o) begin
        if (sb.size() == 0) fail_evt("in_yumi_unexpected");
        else chk("in_yumi_cycle", 64'(cyc), 64'(sb[0].ycyc));
      end
      prev_yumi = bus.in_yumi_o;
    end
  end

  task automatic clear_xcel();
    bus.xcel_yumi_i     = '0;
    bus.xcel_ret_v_i    = '0;
    bus.xcel_ret_data_i = '0;
  endtask

  // One endpoint request; the selected xcel yumis on its k-th ISSUE cycle and returns
  // data m cycles later. Non-selected xcels toggle randomly throughout.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                        input logic [3:0] mask, input int k, input int m, input logic [31:0] rd);
    int sel, lat, c0, n, iss, guard;
    bit mapped, seen;
    logic [31:0] expd;
    logic [NX-1:0] oh, ev, yb, rb;
    logic [NX*32-1:0] dd;
    sel    = int'(addr[11:10]);
    mapped = (sel < NX);
    expd   = rd;
    if (!mapped) begin
      lat = 1; expd = ERR; model_err = 1'b1;
    end else if (k + m <= TO) begin
      lat = 1 + k + m;
    end else begin
      lat = 1 + TO; expd = ERR; model_err = 1'b1;
    end
    iss = !mapped ? 0 : ((k <= TO) ? k : TO);
    oh  = '0;
    if (mapped) oh[sel] = 1'b1;

    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy_o) fail_evt("wait_idle_timeout");

    bus.in_addr_i = addr;
    bus.in_data_i = wd;
    bus.in_we_i   = we;
    bus.in_mask_i = mask;
    bus.in_v_i    = 1'b1;
    c0 = cyc;
    sb.push_back('{expd, c0 + lat});
    n = ((k + m > lat) ? k + m : lat) + 1;
    seen = 1'b0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (bus.in_yumi_o) begin
        seen = 1'b1;
        bus.in_v_i = 1'b0;
      end
      ev = (mapped && j <= iss) ? oh : '0;
      chk("xcel_v_o", 64'(bus.xcel_v_o), 64'(ev));
      if (j == 1) begin
        chk("busy_o", 64'(busy_o), 64'd1);
        chk("xcel_addr_o", 64'(bus.xcel_addr_o), 64'(addr));
        chk("xcel_data_o", 64'(bus.xcel_data_o), 64'(wd));
        chk("xcel_we_o", 64'(bus.xcel_we_o), 64'(we));
        chk("xcel_mask_o", 64'(bus.xcel_mask_o), 64'(mask));
      end
      yb = NX'($urandom);
      rb = NX'($urandom);
      for (int x = 0; x < NX; x++) dd[x*32 +: 32] = $urandom;
      if (mapped) begin
        yb[sel] = (j == k);
        rb[sel] = (j == k + m);
        if (j == k + m) dd[sel*32 +: 32] = rd;
      end
      bus.xcel_yumi_i     = yb;
      bus.xcel_ret_v_i    = rb;
      bus.xcel_ret_data_i = dd;
    end
    clear_xcel();
    if (!seen) begin
      fail_evt("in_yumi_missing");
      bus.in_v_i = 1'b0;
    end
    chk("err_o", 64'(err_o), 64'(model_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    reset_n_i     = 1'b0;
    bus.in_v_i    = 1'b0;
    bus.in_addr_i = '0;
    bus.in_data_i = '0;
    bus.in_mask_i = '0;
    bus.in_we_i   = 1'b0;
    clear_xcel();
    repeat (3) @(negedge clk);
    chk("rst_xcel_v", 64'(bus.xcel_v_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_ret_data", 64'(bus.returning_data_o), 64'd0);
    chk("rst_yumi", 64'(bus.in_yumi_o), 64'd0);
    reset_n_i = 1'b1;

    do_req(32'h404, 32'h15, 1'b1, 4'hF, 1, 2, 32'h0);          // write to xcel1
    do_req(32'h808, 32'h0, 1'b0, 4'hF, 1, 0, 32'h7);           // yumi+ret same cycle
    do_req(32'h400, 32'h1, 1'b0, 4'h3, 16, 0, 32'h1234_5678);  // completes on last counted cycle
    do_req(32'h000, 32'h2, 1'b0, 4'h1, 10, 6, 32'h0BAD_F00D);  // exactly timeout_p cycles
    do_req(32'hC00, 32'h0, 1'b0, 4'hF, 1, 0, 32'h0);           // unmapped
    do_req(32'h804, 32'h3, 1'b1, 4'hF, 3, 2, 32'hAAAA_5555);   // err_o stays sticky
    do_req(32'h000, 32'h4, 1'b0, 4'hF, 10, 7, 32'h1111_2222);  // one cycle past timeout
    do_req(32'h000, 32'h5, 1'b0, 4'hF, 20, 2, 32'h3333_4444);  // never yumis in time, late ret
    do_req(32'h800, 32'h6, 1'b1, 4'h8, 2, 1, 32'h5555_6666);   // queued pair: xcel2 then xcel0
    do_req(32'h000, 32'h7, 1'b0, 4'hF, 1, 1, 32'h7777_8888);

    // Reset while waiting on xcel1's response.
    @(negedge clk);
    bus.in_addr_i = 32'h400; bus.in_data_i = 32'h9; bus.in_we_i = 1'b0; bus.in_mask_i = 4'hF;
    bus.in_v_i = 1'b1;
    @(negedge clk);
    bus.xcel_yumi_i = 3'b010;
    @(negedge clk);
    clear_xcel();
    chk("pre_rst_xcel_v", 64'(bus.xcel_v_o), 64'd0);
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    chk("mid_rst_xcel_addr", 64'(bus.xcel_addr_o), 64'd0);
    chk("mid_rst_yumi", 64'(bus.in_yumi_o), 64'd0);
    chk("mid_rst_ret_v", 64'(bus.returning_v_o), 64'd0);
    bus.in_v_i = 1'b0;
    model_err  = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;
    do_req(32'h400, 32'h9, 1'b0, 4'hF, 1, 2, 32'hCAFE_0001);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      do_req(a, $urandom, 1'($urandom), 4'($urandom), int'($urandom_range(1, 12)),
             int'($urandom_range(0, 8)), $urandom);
    end

    repeat (4) @(negedge clk);
    if (sb.size() != 0) fail_evt("scoreboard_not_drained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
